// File: rtl/eth_test_ctrl.sv
// eth_test_ctrl: Ethernet bring-up controller. It sequences the PHY reset,
// loops received frames back or generates numbered test frames, and keeps
// traffic counters.
// Optional receive payload checker: define ETH_TEST_RX_CHECK_EN.
module eth_test_ctrl #(
  parameter int unsigned PAYLOAD_LEN    = 64,
  parameter int unsigned PHY_RST_CYCLES = 25000000,
  parameter logic [15:0] ETH_TYPE_GEN   = 16'h88B5,
  parameter logic [15:0] ETH_TYPE_LB    = 16'h88B6,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [47:0]          local_mac,
  input  logic [47:0]          peer_mac,
  input  logic                 cnt_clear,
  output logic                 phy_reset_n,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] rx_err_cnt,
  output logic [CNT_WIDTH-1:0] rx_mismatch_cnt,
  input  logic                 s_eth_hdr_valid,
  output logic                 s_eth_hdr_ready,
  input  logic [47:0]          s_eth_dest_mac,
  input  logic [47:0]          s_eth_src_mac,
  input  logic [15:0]          s_eth_type,
  input  logic [7:0]           s_eth_payload_tdata,
  input  logic                 s_eth_payload_tvalid,
  output logic                 s_eth_payload_tready,
  input  logic                 s_eth_payload_tlast,
  input  logic                 s_eth_payload_tuser,
  output logic                 m_eth_hdr_valid,
  input  logic                 m_eth_hdr_ready,
  output logic [47:0]          m_eth_dest_mac,
  output logic [47:0]          m_eth_src_mac,
  output logic [15:0]          m_eth_type,
  output logic [7:0]           m_eth_payload_tdata,
  output logic                 m_eth_payload_tvalid,
  input  logic                 m_eth_payload_tready,
  output logic                 m_eth_payload_tlast,
  output logic                 m_eth_payload_tuser
);

  localparam int unsigned PHY_W = (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN);

  typedef enum logic [2:0] {IDLE, LB_HDR, LB_PAY, GEN_HDR, GEN_PAY} state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 phy_rn_q;
  logic [PHY_W-1:0]     phy_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [31:0]          seq_q;
  logic [CNT_WIDTH-1:0] tx_cnt_q, rx_cnt_q, err_cnt_q;
  logic [7:0]           gen_byte;
  logic                 gen_last;
  logic                 m_hdr_hs, s_hdr_hs, m_pay_hs, s_pay_hs, rx_type_ok;
  logic                 unused_dest;

  // The sink never forwards the received destination address.
  assign unused_dest = ^s_eth_dest_mac;

  assign phy_reset_n = phy_rn_q;
  assign busy        = busy_q;
  assign tx_pkt_cnt  = tx_cnt_q;
  assign rx_pkt_cnt  = rx_cnt_q;
  assign rx_err_cnt  = err_cnt_q;

  assign m_hdr_hs   = m_eth_hdr_valid & m_eth_hdr_ready;
  assign s_hdr_hs   = s_eth_hdr_valid & s_eth_hdr_ready;
  assign m_pay_hs   = m_eth_payload_tvalid & m_eth_payload_tready;
  assign s_pay_hs   = s_eth_payload_tvalid & s_eth_payload_tready;
  assign rx_type_ok = (s_eth_type == ETH_TYPE_GEN) || (s_eth_type == ETH_TYPE_LB);
  assign gen_last   = (idx_q == IDX_W'(PAYLOAD_LEN - 1));

  // Hold the PHY in reset for PHY_RST_CYCLES after rst, then release for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      phy_cnt_q <= '0;
      phy_rn_q  <= 1'b0;
    end else if (!phy_rn_q) begin
      if (phy_cnt_q == PHY_W'(PHY_RST_CYCLES - 1)) phy_rn_q <= 1'b1;
      else phy_cnt_q <= phy_cnt_q + PHY_W'(1);
    end
  end

  // Generated payload: big-endian sequence number, then the byte index.
  always_comb begin
    gen_byte = 8'(idx_q);
    if (idx_q < IDX_W'(4)) begin
      case (idx_q[1:0])
        2'd0:    gen_byte = seq_q[31:24];
        2'd1:    gen_byte = seq_q[23:16];
        2'd2:    gen_byte = seq_q[15:8];
        default: gen_byte = seq_q[7:0];
      endcase
    end
  end

  // Stream steering per state; everything is gated off while the PHY is in reset.
  always_comb begin
    m_eth_hdr_valid      = 1'b0;
    s_eth_hdr_ready      = 1'b0;
    m_eth_dest_mac       = peer_mac;
    m_eth_src_mac        = local_mac;
    m_eth_type           = ETH_TYPE_GEN;
    m_eth_payload_tdata  = gen_byte;
    m_eth_payload_tvalid = 1'b0;
    m_eth_payload_tlast  = gen_last;
    m_eth_payload_tuser  = 1'b0;
    s_eth_payload_tready = 1'b0;
    if (phy_rn_q) begin
      case (state_q)
        LB_HDR: begin
          m_eth_hdr_valid = s_eth_hdr_valid;
          s_eth_hdr_ready = m_eth_hdr_ready;
          m_eth_dest_mac  = s_eth_src_mac;
          m_eth_type      = ETH_TYPE_LB;
        end
        LB_PAY: begin
          m_eth_payload_tdata  = s_eth_payload_tdata;
          m_eth_payload_tvalid = s_eth_payload_tvalid;
          m_eth_payload_tlast  = s_eth_payload_tlast;
          m_eth_payload_tuser  = s_eth_payload_tuser;
          s_eth_payload_tready = m_eth_payload_tready;
        end
        GEN_HDR: begin
          m_eth_hdr_valid      = 1'b1;
          s_eth_hdr_ready      = 1'b1;
          s_eth_payload_tready = 1'b1;
        end
        GEN_PAY: begin
          m_eth_payload_tvalid = 1'b1;
          s_eth_hdr_ready      = 1'b1;
          s_eth_payload_tready = 1'b1;
        end
        default: begin
          s_eth_hdr_ready      = 1'b1;
          s_eth_payload_tready = 1'b1;
        end
      endcase
    end
  end

  // Frame sequencer; mode is only looked at while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (phy_rn_q && mode == 2'd1) begin
            state_q <= LB_HDR;
            busy_q  <= 1'b1;
          end else if (phy_rn_q && mode == 2'd2) begin
            state_q <= GEN_HDR;
            busy_q  <= 1'b1;
          end
        end
        LB_HDR: if (m_hdr_hs) state_q <= LB_PAY;
        LB_PAY: begin
          if (m_pay_hs && m_eth_payload_tlast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GEN_HDR: begin
          if (m_hdr_hs) begin
            seq_q   <= 32'(tx_cnt_q);
            idx_q   <= '0;
            state_q <= GEN_PAY;
          end
        end
        GEN_PAY: begin
          if (m_pay_hs) begin
            if (gen_last) begin
              idx_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Traffic counters; clear takes priority over any increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (m_hdr_hs) tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(1);
      if (s_hdr_hs && rx_type_ok) rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
      if (s_pay_hs && s_eth_payload_tlast && s_eth_payload_tuser) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef ETH_TEST_RX_CHECK_EN
  localparam int unsigned RX_W = IDX_W + 1;

  logic [RX_W-1:0]      rx_idx_q;
  logic                 rx_gen_q, rx_bad_q;
  logic [CNT_WIDTH-1:0] mm_cnt_q;
  logic                 rx_byte_bad, rx_frame_bad;

  assign rx_mismatch_cnt = mm_cnt_q;

  // The index saturates at PAYLOAD_LEN so an over-long frame stays flagged.
  always_comb begin
    rx_byte_bad  = (rx_idx_q >= RX_W'(4)) && (rx_idx_q < RX_W'(PAYLOAD_LEN)) &&
                   (s_eth_payload_tdata != 8'(rx_idx_q));
    rx_frame_bad = rx_bad_q || rx_byte_bad || (rx_idx_q != RX_W'(PAYLOAD_LEN - 1));
  end

  // Check received generator-type payloads against the index pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_idx_q <= '0;
      rx_gen_q <= 1'b0;
      rx_bad_q <= 1'b0;
      mm_cnt_q <= '0;
    end else begin
      if (s_hdr_hs) rx_gen_q <= (s_eth_type == ETH_TYPE_GEN);
      if (s_pay_hs) begin
        if (s_eth_payload_tlast) begin
          rx_idx_q <= '0;
          rx_bad_q <= 1'b0;
        end else begin
          if (rx_idx_q != RX_W'(PAYLOAD_LEN)) rx_idx_q <= rx_idx_q + RX_W'(1);
          rx_bad_q <= rx_bad_q | rx_byte_bad;
        end
      end
      if (cnt_clear) mm_cnt_q <= '0;
      else if (s_pay_hs && s_eth_payload_tlast && rx_gen_q && rx_frame_bad)
        mm_cnt_q <= mm_cnt_q + CNT_WIDTH'(1);
    end
  end
`else
  assign rx_mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_test_ctrl.sv
// Testbench for eth_test_ctrl: randomized traffic against a frame-level model.
module tb_eth_test_ctrl;
  localparam int unsigned PL   = 8;
  localparam int unsigned PHYC = 10;
  localparam int unsigned CW   = 4;
  localparam logic [15:0] T_GEN = 16'h88B5;
  localparam logic [15:0] T_LB  = 16'h88B6;
`ifdef ETH_TEST_RX_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [47:0] local_mac = 48'h02AA_BBCC_DD01, peer_mac = 48'h02FF_EEDD_CC02;
  logic cnt_clear = 1'b0;
  logic phy_reset_n, busy;
  logic [CW-1:0] tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt;
  logic s_hdr_valid = 1'b0, s_hdr_ready;
  logic [47:0] s_dest = '0, s_src = '0;
  logic [15:0] s_type = '0;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_hdr_valid, m_hdr_ready = 1'b0;
  logic [47:0] m_dest, m_src;
  logic [15:0] m_type;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 1'b0, m_tlast, m_tuser;

  int checks = 0, failures = 0;
  int unsigned tx_m = 0, rx_m = 0, err_m = 0, mm_m = 0;
  logic [7:0] fbuf [0:15];

  eth_test_ctrl #(.PAYLOAD_LEN(PL), .PHY_RST_CYCLES(PHYC), .ETH_TYPE_GEN(T_GEN),
                  .ETH_TYPE_LB(T_LB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .local_mac(local_mac), .peer_mac(peer_mac),
    .cnt_clear(cnt_clear), .phy_reset_n(phy_reset_n), .busy(busy),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt),
    .rx_mismatch_cnt(rx_mismatch_cnt),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready), .s_eth_dest_mac(s_dest),
    .s_eth_src_mac(s_src), .s_eth_type(s_type), .s_eth_payload_tdata(s_tdata),
    .s_eth_payload_tvalid(s_tvalid), .s_eth_payload_tready(s_tready),
    .s_eth_payload_tlast(s_tlast), .s_eth_payload_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready), .m_eth_dest_mac(m_dest),
    .m_eth_src_mac(m_src), .m_eth_type(m_type), .m_eth_payload_tdata(m_tdata),
    .m_eth_payload_tvalid(m_tvalid), .m_eth_payload_tready(m_tready),
    .m_eth_payload_tlast(m_tlast), .m_eth_payload_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_gen(input int unsigned seq, input int unsigned i);
    if (i < 4) return 8'((seq >> (8 * (3 - i))) & 32'hFF);
    return 8'(i);
  endfunction

  function automatic bit frame_bad(input logic [15:0] typ, input int unsigned len);
    if (typ != T_GEN) return 1'b0;
    if (len != PL) return 1'b1;
    for (int unsigned i = 4; i < len; i++) if (fbuf[i] != 8'(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] pick_type();
    case ($urandom % 3)
      0: return T_GEN;
      1: return T_LB;
      default: return 16'h0800;
    endcase
  endfunction

  task automatic test_reset();
    int unsigned n = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({phy_reset_n, busy, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt,
         m_hdr_valid, s_hdr_ready, m_tvalid, s_tready} !== '0) begin
      failures++;
      $display("FAIL reset_state got phy=%b busy=%b tx=%0d rx=%0d err=%0d mm=%0d mv=%b sr=%b mtv=%b str=%b exp all zero",
               phy_reset_n, busy, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt,
               m_hdr_valid, s_hdr_ready, m_tvalid, s_tready);
    end
    // Offer traffic and request generation while the PHY is still held.
    mode = 2'd2; s_hdr_valid = 1'b1; s_type = T_GEN;
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tuser = 1'b1; m_hdr_ready = 1'b1; m_tready = 1'b1;
    rst = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (phy_reset_n === 1'b1) break;
      checks++;
      if ({s_hdr_ready, s_tready, m_hdr_valid, m_tvalid, busy} !== 5'b0) begin
        failures++;
        $display("FAIL phy_hold cycle=%0d got sr=%b str=%b mv=%b mtv=%b busy=%b exp 0",
                 n, s_hdr_ready, s_tready, m_hdr_valid, m_tvalid, busy);
      end
    end
    mode = 2'd0; s_hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    checks++;
    if (n != PHYC || phy_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL phy_release got cycles=%0d phy=%b exp cycles=%0d phy=1", n, phy_reset_n, PHYC);
    end
    @(negedge clk);
    checks++;
    if ({busy, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt} !== '0) begin
      failures++;
      $display("FAIL phy_hold_counts got busy=%b tx=%0d rx=%0d err=%0d exp 0",
               busy, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt);
    end
  endtask

  task automatic gen_frames(input int unsigned n, input bit stall);
    int unsigned hdrs = 0, done = 0, bi = 0, seq = 0, cyc = 0;
    mode = 2'd2;
    while (done < n && cyc < 3000) begin
      m_hdr_ready = stall ? 1'($urandom % 2) : 1'b1;
      m_tready    = stall ? 1'(($urandom % 4) != 0) : 1'b1;
      s_hdr_valid = 1'($urandom % 2);
      s_type      = pick_type();
      s_src       = 48'({$urandom, $urandom});
      #1;
      checks++;
      if (s_hdr_ready !== 1'b1) begin
        failures++;
        $display("FAIL gen_sink_ready got %b exp 1", s_hdr_ready);
      end
      if (s_hdr_valid && s_type != 16'h0800) rx_m++;
      if (m_hdr_valid === 1'b1) begin
        checks++;
        if ({m_dest, m_src, m_type} !== {peer_mac, local_mac, T_GEN}) begin
          failures++;
          $display("FAIL gen_hdr got dest=%h src=%h type=%h exp dest=%h src=%h type=%h",
                   m_dest, m_src, m_type, peer_mac, local_mac, T_GEN);
        end
        if (m_hdr_ready) begin
          seq = tx_m % 16; tx_m++; hdrs++; bi = 0;
        end
      end
      if (m_tvalid === 1'b1 && m_tready) begin
        checks++;
        if ({m_tdata, m_tlast, m_tuser, busy} !== {exp_gen(seq, bi), 1'(bi == PL - 1), 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL gen_byte idx=%0d got data=%h last=%b user=%b busy=%b exp data=%h last=%b user=0 busy=1",
                   bi, m_tdata, m_tlast, m_tuser, busy, exp_gen(seq, bi), (bi == PL - 1));
        end
        if (bi == PL - 1) done++;
        bi++;
        if (hdrs == n && bi >= 2) mode = 2'd0;
      end
      @(negedge clk);
      cyc++;
    end
    mode = 2'd0; s_hdr_valid = 1'b0; m_hdr_ready = 1'b0; m_tready = 1'b0;
    checks++;
    if (done < n || busy !== 1'b0 || m_hdr_valid !== 1'b0 || tx_pkt_cnt !== 4'(tx_m) || rx_pkt_cnt !== 4'(rx_m)) begin
      failures++;
      $display("FAIL gen_end got frames=%0d busy=%b mv=%b tx=%0d rx=%0d exp frames=%0d busy=0 mv=0 tx=%0d rx=%0d",
               done, busy, m_hdr_valid, tx_pkt_cnt, rx_pkt_cnt, n, 4'(tx_m), 4'(rx_m));
    end
  endtask

  task automatic test_generate();
    gen_frames(2, 1'b0);
    checks++;
    if (tx_pkt_cnt !== 4'd2) begin
      failures++;
      $display("FAIL gen_tx_two got %0d exp 2", tx_pkt_cnt);
    end
  endtask

  task automatic test_gen_stalls();
    gen_frames(3, 1'b1);
  endtask

  task automatic lb_frame(input logic [47:0] src, input logic [15:0] typ, input int unsigned len,
                          input logic user, input bit stall);
    int unsigned i = 0, cyc = 0;
    bit hs = 0, last;
    logic u;
    mode = 2'd1; s_hdr_valid = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL lb_busy got %b exp 1", busy);
    end
    while (!hs && cyc < 200) begin
      s_hdr_valid = stall ? 1'($urandom % 2) : 1'b1;
      m_hdr_ready = stall ? 1'($urandom % 2) : 1'b1;
      s_src = src; s_type = typ; s_dest = 48'({$urandom, $urandom});
      #1;
      checks++;
      if ({m_hdr_valid, s_hdr_ready, m_dest, m_src, m_type} !== {s_hdr_valid, m_hdr_ready, src, local_mac, T_LB}) begin
        failures++;
        $display("FAIL lb_hdr got v=%b r=%b dest=%h src=%h type=%h exp v=%b r=%b dest=%h src=%h type=%h",
                 m_hdr_valid, s_hdr_ready, m_dest, m_src, m_type, s_hdr_valid, m_hdr_ready, src, local_mac, T_LB);
      end
      hs = s_hdr_valid && m_hdr_ready;
      if (hs) begin
        tx_m++;
        if (typ == T_GEN || typ == T_LB) rx_m++;
      end
      @(negedge clk);
      cyc++;
    end
    s_hdr_valid = 1'b0; mode = 2'd0;
    while (i < len && cyc < 400) begin
      last = (i == len - 1);
      u = last ? user : 1'($urandom % 2);
      s_tvalid = stall ? 1'($urandom % 2) : 1'b1;
      m_tready = stall ? 1'($urandom % 2) : 1'b1;
      s_tdata = fbuf[i]; s_tlast = last; s_tuser = u;
      #1;
      checks++;
      if ({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready} !== {s_tvalid, fbuf[i], last, u, m_tready}) begin
        failures++;
        $display("FAIL lb_pay idx=%0d got v=%b d=%h l=%b u=%b r=%b exp v=%b d=%h l=%b u=%b r=%b",
                 i, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, s_tvalid, fbuf[i], last, u, m_tready);
      end
      if (s_tvalid && m_tready) begin
        if (last) begin
          if (user) err_m++;
          if (CHK_EN && frame_bad(typ, len)) mm_m++;
        end
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b0; m_hdr_ready = 1'b0;
    checks++;
    if (i != len || busy !== 1'b0 || {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt} !==
        {4'(tx_m), 4'(rx_m), 4'(err_m), 4'(mm_m)}) begin
      failures++;
      $display("FAIL lb_end got bytes=%0d busy=%b tx=%0d rx=%0d err=%0d mm=%0d exp bytes=%0d busy=0 tx=%0d rx=%0d err=%0d mm=%0d",
               i, busy, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt, len,
               4'(tx_m), 4'(rx_m), 4'(err_m), 4'(mm_m));
    end
  endtask

  task automatic test_loopback();
    int unsigned len;
    fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC;
    lb_frame(48'h0200_0000_0001, 16'h0800, 3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(1, 12);
      for (int unsigned j = 0; j < 16; j++) fbuf[j] = 8'($urandom);
      lb_frame(48'({$urandom, $urandom}), pick_type(), len, 1'($urandom % 2), 1'b1);
    end
  endtask

  task automatic test_sink_idle();
    logic [15:0] typ;
    int unsigned len;
    logic u;
    mode = 2'd0;
    for (int k = 0; k < 12; k++) begin
      typ = pick_type();
      if ($urandom % 2) begin
        len = PL;
        for (int unsigned j = 0; j < 16; j++) fbuf[j] = 8'(j);
      end else begin
        len = $urandom_range(1, 10);
        for (int unsigned j = 0; j < 16; j++) fbuf[j] = 8'($urandom);
      end
      u = 1'($urandom % 2);
      s_hdr_valid = 1'b1; s_type = typ; s_src = 48'({$urandom, $urandom});
      #1;
      checks++;
      if ({s_hdr_ready, m_hdr_valid, busy} !== 3'b100) begin
        failures++;
        $display("FAIL idle_hdr got sr=%b mv=%b busy=%b exp 1 0 0", s_hdr_ready, m_hdr_valid, busy);
      end
      if (typ != 16'h0800) rx_m++;
      @(negedge clk);
      s_hdr_valid = 1'b0;
      for (int unsigned i = 0; i < len; i++) begin
        s_tvalid = 1'b1; s_tdata = fbuf[i]; s_tlast = (i == len - 1); s_tuser = u;
        #1;
        checks++;
        if ({s_tready, m_tvalid} !== 2'b10) begin
          failures++;
          $display("FAIL idle_pay got str=%b mtv=%b exp 1 0", s_tready, m_tvalid);
        end
        @(negedge clk);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      if (u) err_m++;
      if (CHK_EN && frame_bad(typ, len)) mm_m++;
    end
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt} !== {4'(tx_m), 4'(rx_m), 4'(err_m), 4'(mm_m)}) begin
      failures++;
      $display("FAIL idle_counts got tx=%0d rx=%0d err=%0d mm=%0d exp tx=%0d rx=%0d err=%0d mm=%0d",
               tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt, 4'(tx_m), 4'(rx_m), 4'(err_m), 4'(mm_m));
    end
  endtask

  task automatic test_rx_check();
    for (int unsigned j = 0; j < 16; j++) fbuf[j] = 8'(j);
    fbuf[0] = 8'h00; fbuf[1] = 8'h00; fbuf[2] = 8'h00; fbuf[3] = 8'h07;
    lb_frame(peer_mac, T_GEN, PL, 1'b0, 1'b0);
    fbuf[5] = 8'h55;
    lb_frame(peer_mac, T_GEN, PL, 1'b0, 1'b0);
    fbuf[5] = 8'h05;
    lb_frame(peer_mac, T_GEN, PL, 1'b0, 1'b1);
    lb_frame(peer_mac, T_GEN, 6, 1'b0, 1'b0);
    checks++;
    if (rx_mismatch_cnt !== 4'(CHK_EN ? 2 : 0) || mm_m != (CHK_EN ? 2 : 0)) begin
      failures++;
      $display("FAIL rx_check got mm=%0d exp %0d", rx_mismatch_cnt, CHK_EN ? 2 : 0);
    end
  endtask

  task automatic test_wrap();
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    tx_m = 0; rx_m = 0; err_m = 0; mm_m = 0;
    for (int k = 1; k <= 16; k++) begin
      s_hdr_valid = 1'b1; s_type = (k % 2) ? T_GEN : T_LB;
      @(negedge clk);
      rx_m++;
      if (k == 15 || k == 16) begin
        checks++;
        if (rx_pkt_cnt !== 4'(rx_m)) begin
          failures++;
          $display("FAIL rx_wrap frames=%0d got %0d exp %0d", k, rx_pkt_cnt, 4'(rx_m));
        end
      end
    end
    s_hdr_valid = 1'b0;
  endtask

  task automatic test_clear_coincident();
    s_hdr_valid = 1'b1; s_type = T_GEN; s_tvalid = 1'b1; s_tlast = 1'b1; s_tuser = 1'b1;
    @(negedge clk);
    rx_m++; err_m++;
    checks++;
    if ({rx_pkt_cnt, rx_err_cnt} !== {4'(rx_m), 4'(err_m)}) begin
      failures++;
      $display("FAIL pre_clear got rx=%0d err=%0d exp rx=%0d err=%0d", rx_pkt_cnt, rx_err_cnt, 4'(rx_m), 4'(err_m));
    end
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0; s_hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    tx_m = 0; rx_m = 0; err_m = 0; mm_m = 0;
    checks++;
    if ({tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt} !== '0) begin
      failures++;
      $display("FAIL clear_wins got tx=%0d rx=%0d err=%0d mm=%0d exp 0",
               tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned seen = 0, cyc = 0, n = 0;
    mode = 2'd2; m_hdr_ready = 1'b1; m_tready = 1'b1;
    while (seen < 3 && cyc < 50) begin
      #1;
      if (m_tvalid === 1'b1) seen++;
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1; mode = 2'd0;
    @(negedge clk);
    checks++;
    if (seen < 3 || {m_tvalid, m_hdr_valid, busy, phy_reset_n, tx_pkt_cnt} !== '0) begin
      failures++;
      $display("FAIL midframe_reset got bytes=%0d mtv=%b mv=%b busy=%b phy=%b tx=%0d exp bytes=3 all 0",
               seen, m_tvalid, m_hdr_valid, busy, phy_reset_n, tx_pkt_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (phy_reset_n !== 1'b1 && n < 100) begin
      checks++;
      if (m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL midframe_quiet got mtv=%b exp 0", m_tvalid);
      end
      @(negedge clk);
      n++;
    end
    tx_m = 0; rx_m = 0; err_m = 0; mm_m = 0;
    checks++;
    if (phy_reset_n !== 1'b1 || n != PHYC || busy !== 1'b0 || tx_pkt_cnt !== 4'd0) begin
      failures++;
      $display("FAIL midframe_recover got phy=%b cycles=%0d busy=%b tx=%0d exp phy=1 cycles=%0d busy=0 tx=0",
               phy_reset_n, n, busy, tx_pkt_cnt, PHYC);
    end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_gen_stalls();
    test_loopback();
    test_sink_idle();
    test_rx_check();
    test_wrap();
    test_clear_coincident();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_test_ctrl.md
ETH_TEST_CTRL -- requirements
Module: eth_test_ctrl

Interface
REQ-001 SHALL have parameters: PAYLOAD_LEN, 64, generated payload bytes (>=4); PHY_RST_CYCLES, 25000000, PHY reset hold cycles; ETH_TYPE_GEN, 16'h88B5, generated ethertype; ETH_TYPE_LB, 16'h88B6, looped-back ethertype; CNT_WIDTH, 32, counter width.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset (synchronous, active-high); mode  in  2  0=idle, 1=loopback, 2=generate, 3=idle; local_mac  in  48  own MAC; peer_mac  in  48  generator destination MAC; cnt_clear  in  1  zero all counters.
REQ-003 SHALL have ports: phy_reset_n  out  1  PHY reset; busy  out  1  FSM not in IDLE; tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_mismatch_cnt  out  CNT_WIDTH each.
REQ-004 SHALL have an 8-bit frame sink s_eth_* (hdr_valid/ready, dest_mac, src_mac, type, payload tdata/tvalid/tready/tlast/tuser) and an identical frame source m_eth_*.

Function
REQ-005 PHY reset: counter runs 0..PHY_RST_CYCLES-1; phy_reset_n=0 until the counter saturates, then 1 and held until rst.
REQ-006 While phy_reset_n=0: m hdr/payload valid=0, s hdr/payload ready=0, FSM held in IDLE.
REQ-007 FSM states: IDLE, LB_HDR, LB_PAY, GEN_HDR, GEN_PAY.
REQ-008 mode is sampled only in IDLE: 1 -> LB_HDR, 2 -> GEN_HDR, else stay IDLE; changes mid-frame have no effect until return to IDLE.
REQ-009 LB_HDR: m_hdr_valid=s_hdr_valid, s_hdr_ready=m_hdr_ready, m dest=s src_mac, m src=local_mac, m type=ETH_TYPE_LB (combinational, zero latency); on handshake -> LB_PAY.
REQ-010 LB_PAY: payload passed through combinationally (tdata/tvalid/tlast/tuser forward, tready back); s_hdr_ready=0; on tlast handshake -> IDLE.
REQ-011 GEN_HDR: m_hdr_valid=1, dest=peer_mac, src=local_mac, type=ETH_TYPE_GEN, fields stable while valid; on handshake capture tx_pkt_cnt as seq, -> GEN_PAY.
REQ-012 GEN_PAY: byte i (0..PAYLOAD_LEN-1) = seq[31:24], seq[23:16], seq[15:8], seq[7:0] for i=0..3, else i[7:0]; tlast only at i=PAYLOAD_LEN-1; tuser=0; i advances only on handshake; after last byte -> IDLE.
REQ-013 In IDLE, GEN_HDR and GEN_PAY, s header and payload are sunk (ready=1) and discarded.
REQ-014 tx_pkt_cnt +1 per m header handshake; rx_pkt_cnt +1 per s header handshake with type ETH_TYPE_GEN or ETH_TYPE_LB; rx_err_cnt +1 per s payload tlast handshake with tuser=1.
REQ-015 Counters wrap modulo 2^CNT_WIDTH; cnt_clear zeroes all counters next cycle and wins over a coincident increment.
REQ-016 busy=1 in any state other than IDLE, registered from state.

Reset
REQ-017 rst: FSM=IDLE, PHY counter=0, phy_reset_n=0, all counters=0, byte index=0, seq=0, all valid/ready outputs=0, busy=0.
REQ-018 rst mid-frame abandons the frame immediately; no tlast is emitted for it.

Configuration
REQ-019 Macro ETH_TEST_RX_CHECK_EN defined: received frames of type ETH_TYPE_GEN have payload bytes 4..PAYLOAD_LEN-1 compared against i[7:0]; a frame with any mismatch, or with tlast at any index other than PAYLOAD_LEN-1, increments rx_mismatch_cnt once at its tlast handshake; this check is active in every state, including loopback.
REQ-020 Macro undefined: rx_mismatch_cnt tied to 0 and no checker logic is present.

Verification
REQ-021 PHY_RST_CYCLES=10: release rst -> phy_reset_n rises exactly 10 cycles later; no handshakes are accepted before then.
REQ-022 mode=2, PAYLOAD_LEN=8, m ready=1 -> header dest=peer_mac, type 88B5; payload 00 00 00 00 04 05 06 07 with tlast on the 8th byte; second frame starts 00 00 00 01; tx_pkt_cnt=2.
REQ-023 mode=1, inject frame src=02:00:00:00:00:01, 3 bytes AA BB CC, tuser=1 -> output dest=02:00:00:00:00:01, src=local_mac, type 88B6, same bytes, same cycles; rx_err_cnt=1.
REQ-024 Random m tready stalls in generate mode -> no byte lost or duplicated; mode switched to 0 mid-payload -> current frame completes, then FSM is IDLE.
REQ-025 CNT_WIDTH=4, 16 frames received -> rx_pkt_cnt=0; cnt_clear asserted on the same cycle as a header handshake -> all counters=0.
REQ-026 With ETH_TEST_RX_CHECK_EN defined: loop generator frames back with byte 5 corrupted -> rx_mismatch_cnt=1; an uncorrupted frame leaves it unchanged.
